// File: rtl/parking_timer_bank.sv
// Bank of independent parking-slot stay timers with a fractional prescaler,
// per-slot exit capture held for billing, and a sticky overflow flag.
module parking_timer_bank #(
  parameter int unsigned N_SLOTS   = 4,
  parameter int unsigned TIME_W    = 12,
  parameter int unsigned PRE_W     = 13,
  parameter int unsigned PRE_STEP  = 30,
  parameter int unsigned PRE_LIMIT = 60,
  parameter int unsigned MAX_TIME  = 24,
  parameter int unsigned WRAP_MODE = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_SLOTS-1:0]          start,
  input  logic [N_SLOTS-1:0]          clear,
  output logic [N_SLOTS*TIME_W-1:0]   time_out,
  output logic [N_SLOTS*TIME_W-1:0]   cap_time,
  output logic [N_SLOTS-1:0]          cap_valid,
  output logic [N_SLOTS-1:0]          exit_pulse,
  output logic [N_SLOTS-1:0]          ovf
);

  localparam int unsigned SUM_W = PRE_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t              state_q [N_SLOTS];
  state_t              state_d [N_SLOTS];
  logic [PRE_W-1:0]    pre_q   [N_SLOTS];
  logic [PRE_W-1:0]    pre_d   [N_SLOTS];
  logic [TIME_W-1:0]   time_q  [N_SLOTS];
  logic [TIME_W-1:0]   time_d  [N_SLOTS];
  logic [TIME_W-1:0]   cap_q   [N_SLOTS];
  logic [TIME_W-1:0]   cap_d   [N_SLOTS];
  logic [SUM_W-1:0]    sum     [N_SLOTS];
  logic [N_SLOTS-1:0]  tick;
  logic [N_SLOTS-1:0]  capv_q, capv_d;
  logic [N_SLOTS-1:0]  exit_q, exit_d;
  logic [N_SLOTS-1:0]  ovf_q,  ovf_d;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(N_SLOTS); i++) begin
        state_q[i] <= S_IDLE;
        pre_q[i]   <= '0;
        time_q[i]  <= '0;
        cap_q[i]   <= '0;
      end
      capv_q <= '0;
      exit_q <= '0;
      ovf_q  <= '0;
    end else begin
      for (int i = 0; i < int'(N_SLOTS); i++) begin
        state_q[i] <= state_d[i];
        pre_q[i]   <= pre_d[i];
        time_q[i]  <= time_d[i];
        cap_q[i]   <= cap_d[i];
      end
      capv_q <= capv_d;
      exit_q <= exit_d;
      ovf_q  <= ovf_d;
    end
  end

  // Next-state logic
  always_comb begin
    for (int i = 0; i < int'(N_SLOTS); i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        S_IDLE:  if (start[i])  state_d[i] = S_RUN;
        S_RUN:   if (!start[i]) state_d[i] = S_HOLD;
        S_HOLD:  if (clear[i])  state_d[i] = S_IDLE;
        default: state_d[i] = S_IDLE;
      endcase
    end
  end

  // Prescaler sum is one bit wider so the carry past PRE_LIMIT is never lost
  always_comb begin
    for (int i = 0; i < int'(N_SLOTS); i++) begin
      sum[i]  = {1'b0, pre_q[i]} + SUM_W'(PRE_STEP);
      tick[i] = (sum[i] >= SUM_W'(PRE_LIMIT));
    end
  end

  // Datapath next values; capture on exit overrides a same-edge clear
  always_comb begin
    capv_d = capv_q;
    exit_d = '0;
    ovf_d  = ovf_q;
    for (int i = 0; i < int'(N_SLOTS); i++) begin
      pre_d[i]  = pre_q[i];
      time_d[i] = time_q[i];
      cap_d[i]  = cap_q[i];
      if (clear[i]) begin
        capv_d[i] = 1'b0;
        cap_d[i]  = '0;
        ovf_d[i]  = 1'b0;
      end
      case (state_q[i])
        S_RUN: begin
          if (start[i]) begin
            pre_d[i] = tick[i] ? PRE_W'(sum[i] - SUM_W'(PRE_LIMIT)) : PRE_W'(sum[i]);
            if (tick[i]) begin
              if (time_q[i] < TIME_W'(MAX_TIME)) begin
                time_d[i] = time_q[i] + TIME_W'(1);
              end else begin
                ovf_d[i] = 1'b1;
                if (WRAP_MODE != 0) time_d[i] = '0;
              end
            end
          end else begin
            cap_d[i]  = time_q[i];
            capv_d[i] = 1'b1;
            exit_d[i] = 1'b1;
            time_d[i] = '0;
            pre_d[i]  = '0;
          end
        end
        default: begin
          pre_d[i]  = '0;
          time_d[i] = '0;
        end
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < int'(N_SLOTS); i++) begin
      time_out[i*TIME_W +: TIME_W] = time_q[i];
      cap_time[i*TIME_W +: TIME_W] = cap_q[i];
    end
  end

  assign cap_valid  = capv_q;
  assign exit_pulse = exit_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_parking_timer_bank.sv
// Scoreboard bench for parking_timer_bank: a wrapping default instance and a
// saturating MAX_TIME=3 / step-25 instance share randomized start/clear stimulus.
module tb_parking_timer_bank;

  localparam int TW  = 12;
  localparam int LIM = 60;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  start, clear;
  logic [47:0] time_a, cap_a, time_b, cap_b;
  logic [3:0]  cv_a, ex_a, ov_a, cv_b, ex_b, ov_b;

  always #5 clk = ~clk;

  parking_timer_bank dut_a (
    .clk(clk), .rst(rst), .start(start), .clear(clear),
    .time_out(time_a), .cap_time(cap_a), .cap_valid(cv_a),
    .exit_pulse(ex_a), .ovf(ov_a)
  );

  parking_timer_bank #(.PRE_STEP(25), .MAX_TIME(3), .WRAP_MODE(0)) dut_b (
    .clk(clk), .rst(rst), .start(start), .clear(clear),
    .time_out(time_b), .cap_time(cap_b), .cap_valid(cv_b),
    .exit_pulse(ex_b), .ovf(ov_b)
  );

  typedef struct packed {
    logic [47:0] tm_a, cap_a, tm_b, cap_b;
    logic [3:0]  cv_a, ex_a, ov_a, cv_b, ex_b, ov_b;
  } exp_t;

  int step_c [2] = '{30, 25};
  int max_c  [2] = '{24, 3};
  bit wrap_c [2] = '{1'b1, 1'b0};

  // Reference model: a running slot's time is derived from its count of
  // counting edges n as floor(n*STEP/LIMIT), then wrapped or saturated.
  bit   m_act  [2][4];
  bit   m_hold [2][4];
  bit   m_ovf  [2][4];
  bit   m_cv   [2][4];
  int   m_n    [2][4];
  int   m_cap  [2][4];
  int   cap_q  [8][$];
  exp_t exp_q  [$];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic int time_of(int k, int ticks);
    if (wrap_c[k]) return ticks % (max_c[k] + 1);
    return (ticks > max_c[k]) ? max_c[k] : ticks;
  endfunction

  task automatic check(input string nm, input logic [47:0] act, input logic [47:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++) begin
        m_act[k][i] = 0; m_hold[k][i] = 0; m_ovf[k][i] = 0;
        m_cv[k][i] = 0;  m_n[k][i] = 0;    m_cap[k][i] = 0;
      end
    for (int j = 0; j < 8; j++) cap_q[j].delete();
    exp_q.delete();
  endtask

  // Drive inputs for the coming edge, advance the model, queue the expected response
  task automatic apply(input logic [3:0] st, input logic [3:0] cl);
    logic [47:0] tmv [2];
    logic [47:0] cpv [2];
    logic [3:0]  cvv [2];
    logic [3:0]  exv [2];
    logic [3:0]  ovv [2];
    exp_t e;
    int cur, t0, t1;
    start = st;
    clear = cl;
    for (int k = 0; k < 2; k++) begin
      tmv[k] = '0; cpv[k] = '0; cvv[k] = '0; exv[k] = '0; ovv[k] = '0;
      for (int i = 0; i < 4; i++) begin
        cur = m_act[k][i] ? time_of(k, m_n[k][i] * step_c[k] / LIM) : 0;
        if (cl[i]) begin
          m_cv[k][i] = 0; m_cap[k][i] = 0; m_ovf[k][i] = 0;
        end
        if (m_act[k][i]) begin
          if (st[i]) begin
            t0 = m_n[k][i] * step_c[k] / LIM;
            m_n[k][i]++;
            t1 = m_n[k][i] * step_c[k] / LIM;
            if (t1 > t0 && time_of(k, t0) == max_c[k]) m_ovf[k][i] = 1;
          end else begin
            m_cap[k][i] = cur;
            m_cv[k][i]  = 1;
            cap_q[k*4+i].push_back(cur);
            exv[k][i]   = 1'b1;
            m_act[k][i] = 0;
            m_hold[k][i] = 1;
            m_n[k][i]   = 0;
          end
        end else if (m_hold[k][i]) begin
          if (cl[i]) m_hold[k][i] = 0;
        end else if (st[i]) begin
          m_act[k][i] = 1;
          m_n[k][i]   = 0;
        end
        tmv[k][i*TW +: TW] = m_act[k][i] ? TW'(time_of(k, m_n[k][i] * step_c[k] / LIM)) : '0;
        cpv[k][i*TW +: TW] = TW'(m_cap[k][i]);
        cvv[k][i] = m_cv[k][i];
        ovv[k][i] = m_ovf[k][i];
      end
    end
    e.tm_a = tmv[0]; e.cap_a = cpv[0]; e.cv_a = cvv[0]; e.ex_a = exv[0]; e.ov_a = ovv[0];
    e.tm_b = tmv[1]; e.cap_b = cpv[1]; e.cv_b = cvv[1]; e.ex_b = exv[1]; e.ov_b = ovv[1];
    exp_q.push_back(e);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_time_a"}, time_a, '0);
    check({tag, "_cap_a"},  cap_a,  '0);
    check({tag, "_flags_a"}, 48'({cv_a, ex_a, ov_a}), '0);
    check({tag, "_time_b"}, time_b, '0);
    check({tag, "_cap_b"},  cap_b,  '0);
    check({tag, "_flags_b"}, 48'({cv_b, ex_b, ov_b}), '0);
  endtask

  // Monitor: pops one expected record per edge, and one capture per exit pulse
  exp_t        mon_e;
  logic [3:0]  mon_ex;
  logic [47:0] mon_cap;
  int          mon_c;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("time_out_a",   time_a,      mon_e.tm_a);
        check("cap_time_a",   cap_a,       mon_e.cap_a);
        check("cap_valid_a",  48'(cv_a),   48'(mon_e.cv_a));
        check("exit_pulse_a", 48'(ex_a),   48'(mon_e.ex_a));
        check("ovf_a",        48'(ov_a),   48'(mon_e.ov_a));
        check("time_out_b",   time_b,      mon_e.tm_b);
        check("cap_time_b",   cap_b,       mon_e.cap_b);
        check("cap_valid_b",  48'(cv_b),   48'(mon_e.cv_b));
        check("exit_pulse_b", 48'(ex_b),   48'(mon_e.ex_b));
        check("ovf_b",        48'(ov_b),   48'(mon_e.ov_b));
        for (int k = 0; k < 2; k++) begin
          mon_ex  = (k == 0) ? ex_a : ex_b;
          mon_cap = (k == 0) ? cap_a : cap_b;
          for (int i = 0; i < 4; i++) begin
            if (mon_ex[i]) begin
              if (cap_q[k*4+i].size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL exit_unexpected: inst %0d slot %0d pulsed with no capture queued", k, i);
              end else begin
                mon_c = cap_q[k*4+i].pop_front();
                check("exit_capture", 48'(mon_cap[i*TW +: TW]), 48'(mon_c));
              end
            end
          end
        end
      end
    end
  end

  logic [3:0] st_v, cl_v;
  int         left;

  initial begin
    rst   = 1'b1;
    start = '0;
    clear = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // All slots start together; after 10 counting edges time_out_a is 5
    repeat (11) begin
      @(negedge clk);
      apply(4'hF, 4'h0);
    end

    // Asynchronous reset mid-run, start held high throughout
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    apply(4'hF, 4'h0);

    // Slot 0 held long enough to wrap instance a; everything else random
    st_v = 4'hF;
    for (int c = 0; c < 2600; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if ((i != 0 || c >= 70) && $urandom_range(0, 11) == 0) st_v[i] = ~st_v[i];
        cl_v[i] = ($urandom_range(0, 9) == 0);
      end
      apply(st_v, cl_v);
    end

    repeat (4) @(posedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected records never compared, required 0", exp_q.size());
    end
    left = 0;
    for (int j = 0; j < 8; j++) left += cap_q[j].size();
    n_cmp++;
    if (left != 0) begin
      n_bad++;
      $display("FAIL missing_exit: %0d captures without exit pulse, required 0", left);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
